// File: rtl/trigger_pkg.sv
// Shared types and helpers for the trigger sequence generator: state encodings,
// the Q16.16 unit step, the 17-bit sample-pair sum and the stage threshold test.
package trigger_pkg;

    localparam int ADC_W = 16;
    localparam int SUM_W = ADC_W + 1;
    localparam logic [31:0] Q16_ONE = 32'h0001_0000;

    typedef logic signed [SUM_W-1:0] sum_t;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_STAGE   = 3'd1,
        ST_HOLD         = 3'd2,
        ST_WAIT_TRIGGER = 3'd3,
        ST_TRIGGER      = 3'd4
    } state_t;

    function automatic sum_t pair_sum(input logic [2*ADC_W-1:0] data);
        sum_t lo;
        sum_t hi;
        lo = {data[ADC_W-1], data[ADC_W-1:0]};
        hi = {data[2*ADC_W-1], data[2*ADC_W-1:ADC_W]};
        return lo + hi;
    endfunction

    // Thresholds are compared against the two-sample sum, so each level is doubled.
    function automatic logic level_hit(input sum_t s, input logic [31:0] level);
        sum_t thr_p;
        sum_t thr_m;
        thr_p = {level[31:16], 1'b0};
        thr_m = {level[15:0], 1'b0};
        return (s > thr_p) || (s < thr_m);
    endfunction

endpackage

// File: rtl/adc_pair_sum.sv
// Per-channel registered sum of the two samples delivered on each rxclk.
module adc_pair_sum
    import trigger_pkg::*;
(
    input  logic               rxclk,
    input  logic               rst,
    input  logic               en,
    input  logic [2*ADC_W-1:0] data,
    output sum_t               sum
);

    always_ff @(posedge rxclk) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= pair_sum(data);
        end
    end

endmodule

// File: rtl/trigger_seq_gen.sv
// Multi-stage threshold-crossing sequence detector with time-of-flight scaled trigger delay.
// Optional per-stage timeout is built when TRIGGER_SEQ_TIMEOUT_EN is defined.
//
// state           | meaning
// ST_IDLE         | initial dwell of init_hold+1 cycles, flags cleared
// ST_WAIT_STAGE   | waiting for a hit on the current stage
// ST_HOLD         | blanking after a non-final stage hit
// ST_WAIT_TRIGGER | counting up to the accumulated delay
// ST_TRIGGER      | trigger fired
module trigger_seq_gen
    import trigger_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int NUM_STAGES     = 3,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int CH_SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             rxclk,
    input  logic                             rst,
    input  logic [NUM_CH*2*ADC_DATA_WIDTH-1:0] adc_data,
    input  logic [NUM_CH-1:0]                adc_enable,
    input  logic                             trig_enable,
    input  logic                             rearm_mode,
    input  logic [NUM_STAGES*CH_SEL_W-1:0]   stage_ch,
    input  logic [NUM_STAGES*32-1:0]         trig_level,
    input  logic [31:0]                      init_hold,
    input  logic [31:0]                      hold_cycles,
    input  logic [31:0]                      param_mul,
    input  logic [31:0]                      param_off,
    input  logic [31:0]                      timeout_cycles,
    output logic [31:0]                      pulse_tof,
    output logic [31:0]                      delay_time,
    output logic [NUM_STAGES-1:0]            detect_pls,
    output logic                             trig_out,
    output logic                             seq_abort,
    output logic [15:0]                      trig_count,
    output logic [2:0]                       state_o
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    sum_t                  ch_sum [NUM_CH];
    logic [NUM_STAGES-1:0] stage_hit;
    logic [NUM_STAGES-1:0] stage_onehot;
    logic                  cur_hit;
    logic                  last_stage;

    state_t           state;
    logic [31:0]      hold_cnt;
    logic [31:0]      wait_cnt;
    logic [31:0]      counter;
    logic [IDX_W-1:0] stage_idx;
    logic             tof_active;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_pair_sum u_sum (
            .rxclk (rxclk),
            .rst   (rst),
            .en    (adc_enable[c]),
            .data  (adc_data[c*2*ADC_DATA_WIDTH +: 2*ADC_W]),
            .sum   (ch_sum[c])
        );
    end

    // A stage whose channel index matches no channel never hits.
    always_comb begin
        stage_hit = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(stage_ch[k*CH_SEL_W +: CH_SEL_W]) == c) begin
                    stage_hit[k] = level_hit(ch_sum[c], trig_level[k*32 +: 32]);
                end
            end
        end
    end

    always_comb begin
        stage_onehot = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_onehot[k] = (stage_idx == IDX_W'(k));
        end
    end

    assign cur_hit    = |(stage_hit & stage_onehot);
    assign last_stage = (stage_idx == IDX_W'(NUM_STAGES - 1));
    assign state_o    = state;

`ifdef TRIGGER_SEQ_TIMEOUT_EN
    logic [31:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign seq_abort      = 1'b0;
`endif

    always_ff @(posedge rxclk) begin
        if (rst || !trig_enable) begin
            state      <= ST_IDLE;
            hold_cnt   <= init_hold;
            stage_idx  <= '0;
            tof_active <= 1'b0;
            wait_cnt   <= '0;
            counter    <= '0;
            detect_pls <= '0;
            trig_out   <= 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
            seq_abort  <= 1'b0;
            to_cnt     <= '0;
`endif
            if (rst) begin
                pulse_tof  <= '0;
                delay_time <= '0;
                trig_count <= '0;
            end
        end else begin
`ifdef TRIGGER_SEQ_TIMEOUT_EN
            seq_abort <= 1'b0;
            to_cnt    <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    detect_pls <= '0;
                    stage_idx  <= '0;
                    tof_active <= 1'b0;
                    if (hold_cnt == '0) begin
                        state <= ST_WAIT_STAGE;
                    end else begin
                        hold_cnt <= hold_cnt - 32'd1;
                    end
                end

                ST_WAIT_STAGE: begin
                    if (cur_hit) begin
                        detect_pls <= detect_pls | stage_onehot;
                        if (stage_idx == '0) begin
                            delay_time <= '0;
                            wait_cnt   <= '0;
                            tof_active <= 1'b1;
                        end else if (tof_active) begin
                            // The stage 1 hit cycle itself counts toward the flight time.
                            pulse_tof  <= wait_cnt + 32'd1;
                            delay_time <= delay_time + param_mul + param_off;
                            tof_active <= 1'b0;
                        end
                        if (last_stage) begin
                            counter <= '0;
                            state   <= ST_WAIT_TRIGGER;
                        end else begin
                            hold_cnt <= hold_cycles;
                            state    <= ST_HOLD;
                        end
                    end else begin
                        if (tof_active) begin
                            delay_time <= delay_time + param_mul;
                            wait_cnt   <= wait_cnt + 32'd1;
                        end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
                        if (stage_idx != '0) begin
                            if ((timeout_cycles != '0) && (to_cnt + 32'd1 >= timeout_cycles)) begin
                                seq_abort  <= 1'b1;
                                detect_pls <= '0;
                                delay_time <= '0;
                                wait_cnt   <= '0;
                                tof_active <= 1'b0;
                                stage_idx  <= '0;
                            end else begin
                                to_cnt <= to_cnt + 32'd1;
                            end
                        end
`endif
                    end
                end

                ST_HOLD: begin
                    if (tof_active) begin
                        delay_time <= delay_time + param_mul;
                        wait_cnt   <= wait_cnt + 32'd1;
                    end
                    if (hold_cnt == '0) begin
                        state     <= ST_WAIT_STAGE;
                        stage_idx <= stage_idx + IDX_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt - 32'd1;
                    end
                end

                ST_WAIT_TRIGGER: begin
                    counter <= counter + Q16_ONE;
                    if ($signed(counter) >= $signed(delay_time)) begin
                        trig_out <= 1'b1;
                        if (trig_count != 16'hFFFF) begin
                            trig_count <= trig_count + 16'd1;
                        end
                        state <= ST_TRIGGER;
                    end
                end

                ST_TRIGGER: begin
                    // Rearm passes through HOLD with an all-ones index so it wraps to stage 0.
                    if (rearm_mode) begin
                        trig_out   <= 1'b0;
                        detect_pls <= '0;
                        hold_cnt   <= hold_cycles;
                        stage_idx  <= '1;
                        state      <= ST_HOLD;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_seq_gen.sv
// Directed self-checking bench for trigger_seq_gen (default 4 channels, 3 stages).
module tb_trigger_seq_gen;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WS   = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_WT   = 3'd3;
    localparam logic [2:0] S_TRIG = 3'd4;

    logic         rxclk = 1'b0;
    logic         rst;
    logic [127:0] adc_data;
    logic [3:0]   adc_enable;
    logic         trig_enable;
    logic         rearm_mode;
    logic [5:0]   stage_ch;
    logic [95:0]  trig_level;
    logic [31:0]  init_hold;
    logic [31:0]  hold_cycles;
    logic [31:0]  param_mul;
    logic [31:0]  param_off;
    logic [31:0]  timeout_cycles;
    logic [31:0]  pulse_tof;
    logic [31:0]  delay_time;
    logic [2:0]   detect_pls;
    logic         trig_out;
    logic         seq_abort;
    logic [15:0]  trig_count;
    logic [2:0]   state_o;

    int total = 0;
    int bad   = 0;

    always #4 rxclk = ~rxclk;

    trigger_seq_gen dut (
        .rxclk          (rxclk),
        .rst            (rst),
        .adc_data       (adc_data),
        .adc_enable     (adc_enable),
        .trig_enable    (trig_enable),
        .rearm_mode     (rearm_mode),
        .stage_ch       (stage_ch),
        .trig_level     (trig_level),
        .init_hold      (init_hold),
        .hold_cycles    (hold_cycles),
        .param_mul      (param_mul),
        .param_off      (param_off),
        .timeout_cycles (timeout_cycles),
        .pulse_tof      (pulse_tof),
        .delay_time     (delay_time),
        .detect_pls     (detect_pls),
        .trig_out       (trig_out),
        .seq_abort      (seq_abort),
        .trig_count     (trig_count),
        .state_o        (state_o)
    );

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [15:0] s0, input logic [15:0] s1);
        adc_data[c*32 +: 32] = {s1, s0};
    endtask

    // Detection lands on the second edge after the sample is driven.
    task automatic hit_ch(input int c);
        set_ch(c, 16'h0200, 16'h0200);
        tick();
        set_ch(c, 16'h0000, 16'h0000);
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (state_o === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        adc_data = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_IDLE); end
        total++; if ({trig_out, seq_abort, detect_pls} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {trig_out, seq_abort, detect_pls}); end
        total++; if ({pulse_tof, delay_time, trig_count} !== 80'b0) begin bad++; $display("FAIL reset_regs got=%0h exp=0", {pulse_tof, delay_time, trig_count}); end
        rst = 1'b0;
        repeat (3) tick();
        total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL idle_dwell got=%0d exp=%0d", state_o, S_IDLE); end
        tick();
        total++; if (state_o !== S_WS) begin bad++; $display("FAIL idle_exit got=%0d exp=%0d", state_o, S_WS); end
    endtask

    task automatic test_stage0_detect();
        bit ok;
        do_reset();
        wait_state(S_WS, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL s0_wait got=%0d exp=%0d", state_o, S_WS); end
        set_ch(0, 16'h0200, 16'h0200);
        tick();
        set_ch(0, 16'h0000, 16'h0000);
        total++; if (detect_pls !== 3'b000) begin bad++; $display("FAIL s0_early got=%b exp=000", detect_pls); end
        tick();
        total++; if (detect_pls !== 3'b001) begin bad++; $display("FAIL s0_flag got=%b exp=001", detect_pls); end
        total++; if (state_o !== S_HOLD) begin bad++; $display("FAIL s0_state got=%0d exp=%0d", state_o, S_HOLD); end
    endtask

    task automatic test_sequence();
        bit ok;
        do_reset();
        hold_cycles = 32'd10;
        param_mul   = 32'h0001_0000;
        param_off   = 32'h0;
        rearm_mode  = 1'b0;
        wait_state(S_WS, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL seq_wait0 got=%0d exp=%0d", state_o, S_WS); end
        hit_ch(0);
        repeat (48) tick();
        set_ch(1, 16'h0200, 16'h0200);
        tick();
        set_ch(1, 16'h0000, 16'h0000);
        total++; if (detect_pls !== 3'b001) begin bad++; $display("FAIL seq_pre_s1 got=%b exp=001", detect_pls); end
        tick();
        total++; if (detect_pls !== 3'b011) begin bad++; $display("FAIL seq_s1_flag got=%b exp=011", detect_pls); end
        total++; if (pulse_tof !== 32'd50) begin bad++; $display("FAIL seq_tof got=%0d exp=50", pulse_tof); end
        total++; if (delay_time !== 32'h0032_0000) begin bad++; $display("FAIL seq_delay got=%0h exp=320000", delay_time); end
        wait_state(S_WS, 30, ok);
        total++; if (!ok) begin bad++; $display("FAIL seq_wait2 got=%0d exp=%0d", state_o, S_WS); end
        hit_ch(2);
        total++; if (state_o !== S_WT) begin bad++; $display("FAIL seq_s2_state got=%0d exp=%0d", state_o, S_WT); end
        total++; if (detect_pls !== 3'b111) begin bad++; $display("FAIL seq_s2_flag got=%b exp=111", detect_pls); end
        repeat (50) tick();
        total++; if (trig_out !== 1'b0) begin bad++; $display("FAIL seq_trig_early got=%b exp=0", trig_out); end
        tick();
        total++; if (trig_out !== 1'b1) begin bad++; $display("FAIL seq_trig_rise got=%b exp=1", trig_out); end
        total++; if (state_o !== S_TRIG) begin bad++; $display("FAIL seq_trig_state got=%0d exp=%0d", state_o, S_TRIG); end
        total++; if (trig_count !== 16'd1) begin bad++; $display("FAIL seq_count got=%0d exp=1", trig_count); end
        repeat (5) tick();
        total++; if (trig_out !== 1'b1) begin bad++; $display("FAIL oneshot_hold got=%b exp=1", trig_out); end
        trig_enable = 1'b0;
        tick();
        total++; if ({state_o, trig_out, detect_pls} !== 7'b0) begin bad++; $display("FAIL soft_clear got=%b exp=0", {state_o, trig_out, detect_pls}); end
        total++; if (trig_count !== 16'd1 || pulse_tof !== 32'd50 || delay_time !== 32'h0032_0000) begin
            bad++; $display("FAIL soft_keep got=%0d/%0d/%0h exp=1/50/320000", trig_count, pulse_tof, delay_time);
        end
        trig_enable = 1'b1;
    endtask

    task automatic test_negative();
        bit ok;
        do_reset();
        trig_level[31:0] = 32'h0100_FF00;
        wait_state(S_WS, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL neg_wait got=%0d exp=%0d", state_o, S_WS); end
        set_ch(0, 16'hFF00, 16'hFF00);
        tick();
        tick();
        total++; if (detect_pls !== 3'b000 || state_o !== S_WS) begin bad++; $display("FAIL neg_equal got=%b/%0d exp=000/1", detect_pls, state_o); end
        set_ch(0, 16'hFD00, 16'hFD00);
        tick();
        tick();
        total++; if (detect_pls !== 3'b001) begin bad++; $display("FAIL neg_below got=%b exp=001", detect_pls); end
        set_ch(0, 16'h0000, 16'h0000);
        trig_level[31:0] = 32'h0100_8000;
    endtask

    task automatic test_rearm();
        bit ok;
        int highs;
        int first;
        do_reset();
        rearm_mode  = 1'b1;
        hold_cycles = 32'd2;
        param_mul   = 32'h0001_0000;
        param_off   = 32'h0003_0000;
        for (int seq = 1; seq <= 2; seq++) begin
            wait_state(S_WS, 20, ok);
            total++; if (!ok) begin bad++; $display("FAIL rearm_wait0 seq=%0d got=%0d exp=%0d", seq, state_o, S_WS); end
            hit_ch(0);
            repeat (3) tick();
            hit_ch(1);
            total++; if (pulse_tof !== 32'd5) begin bad++; $display("FAIL rearm_tof seq=%0d got=%0d exp=5", seq, pulse_tof); end
            total++; if (delay_time !== 32'h0008_0000) begin bad++; $display("FAIL rearm_delay seq=%0d got=%0h exp=80000", seq, delay_time); end
            wait_state(S_WS, 20, ok);
            total++; if (!ok) begin bad++; $display("FAIL rearm_wait2 seq=%0d got=%0d exp=%0d", seq, state_o, S_WS); end
            hit_ch(2);
            highs = 0;
            first = -1;
            for (int i = 1; i <= 30; i++) begin
                tick();
                if (trig_out === 1'b1) begin
                    highs++;
                    if (first < 0) first = i;
                end
            end
            total++; if (highs !== 1) begin bad++; $display("FAIL rearm_width seq=%0d got=%0d exp=1", seq, highs); end
            total++; if (first !== 9) begin bad++; $display("FAIL rearm_latency seq=%0d got=%0d exp=9", seq, first); end
            total++; if (trig_count !== 16'(seq)) begin bad++; $display("FAIL rearm_count got=%0d exp=%0d", trig_count, seq); end
            total++; if (state_o !== S_WS || detect_pls !== 3'b000) begin bad++; $display("FAIL rearm_back got=%0d/%b exp=1/000", state_o, detect_pls); end
        end
    endtask

    task automatic test_rst_midflight();
        bit ok;
        rearm_mode = 1'b0;
        hit_ch(0);
        repeat (3) tick();
        hit_ch(1);
        wait_state(S_WS, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_wait got=%0d exp=%0d", state_o, S_WS); end
        hit_ch(2);
        repeat (2) tick();
        total++; if (state_o !== S_WT) begin bad++; $display("FAIL mid_wt got=%0d exp=%0d", state_o, S_WT); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (state_o !== S_IDLE || {trig_out, seq_abort, detect_pls} !== 5'b0) begin
            bad++; $display("FAIL mid_rst_flags got=%0d/%b exp=0/0", state_o, {trig_out, seq_abort, detect_pls});
        end
        total++; if ({pulse_tof, delay_time, trig_count} !== 80'b0) begin bad++; $display("FAIL mid_rst_regs got=%0h exp=0", {pulse_tof, delay_time, trig_count}); end
    endtask

    task automatic test_timeout();
        bit ok;
        int first;
        int n_abort;
        logic [2:0]  det_at;
        logic [2:0]  st_at;
        logic [31:0] dly_at;
        do_reset();
        hold_cycles    = 32'd2;
        timeout_cycles = 32'd100;
        wait_state(S_WS, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_wait got=%0d exp=%0d", state_o, S_WS); end
        hit_ch(0);
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        first  = -1;
        det_at = 3'bxxx;
        st_at  = 3'bxxx;
        dly_at = 'x;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (seq_abort === 1'b1) begin
                first  = i;
                det_at = detect_pls;
                st_at  = state_o;
                dly_at = delay_time;
                break;
            end
        end
        total++; if (first !== 103) begin bad++; $display("FAIL to_latency got=%0d exp=103", first); end
        total++; if (det_at !== 3'b000 || st_at !== S_WS || dly_at !== 32'h0) begin
            bad++; $display("FAIL to_clear got=%b/%0d/%0h exp=000/1/0", det_at, st_at, dly_at);
        end
        tick();
        total++; if (seq_abort !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", seq_abort); end
        hit_ch(0);
        total++; if (detect_pls !== 3'b001 || state_o !== S_HOLD) begin bad++; $display("FAIL to_rearmed got=%b/%0d exp=001/2", detect_pls, state_o); end
`else
        first   = 0;
        n_abort = 0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (seq_abort !== 1'b0) n_abort++;
        end
        total++; if (n_abort !== first) begin bad++; $display("FAIL to_disabled got=%0d exp=0", n_abort); end
        total++; if (detect_pls !== 3'b001 || state_o !== S_WS) begin bad++; $display("FAIL to_stays got=%b/%0d exp=001/1", detect_pls, state_o); end
`endif
        timeout_cycles = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        adc_data       = '0;
        adc_enable     = 4'hF;
        trig_enable    = 1'b1;
        rearm_mode     = 1'b0;
        stage_ch       = {2'd2, 2'd1, 2'd0};
        trig_level     = {3{32'h0100_8000}};
        init_hold      = 32'd3;
        hold_cycles    = 32'd10;
        param_mul      = 32'h0001_0000;
        param_off      = 32'h0;
        timeout_cycles = 32'd0;

        test_reset();
        test_stage0_detect();
        test_sequence();
        test_negative();
        test_rearm();
        test_rst_midflight();
        test_timeout();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
